// File: rtl/cmd_reg_arbiter.sv
// cmd_reg_arbiter
// Write arbiter and safety sequencer for the command register bank
// (addresses 25-44). The bank's single write port is shared between the
// SPI host write path and the on-board PID loop. A host-link watchdog
// forces a fixed all-stop write sequence when the host goes quiet.
//
// Ports
//   SYS_CLK                 system clock, rising edge
//   RST                     synchronous active-high reset
//   host_req/addr/data      host write request, held until host_ack
//   host_ack/host_err       one-cycle completion, err=1 means rejected
//   pid_req/addr/data       PID write request, held until pid_ack
//   pid_ack/pid_err         one-cycle completion, err=1 means rejected
//   wdog_en                 watchdog enable
//   wr_en/wr_addr/wr_data   bank write port (one-cycle strobe)
//   estop_active            forced-stop state latched
//
// state | meaning
// IDLE  | grants host/PID requests, watchdog counting
// ES0   | all-stop write (40 <- 001F) on the bus
// ES1   | motor duty write (33 <- 0) on the bus
// ES2   | motor duty write (34 <- 0) on the bus
// ES3   | motor duty write (35 <- 0) on the bus
// ES4   | motor duty write (36 <- 0) on the bus, back to IDLE next
module cmd_reg_arbiter #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000
) (
   input  logic        SYS_CLK,
   input  logic        RST,
   input  logic        host_req,
   input  logic [9:0]  host_addr,
   input  logic [15:0] host_data,
   output logic        host_ack,
   output logic        host_err,
   input  logic        pid_req,
   input  logic [9:0]  pid_addr,
   input  logic [15:0] pid_data,
   output logic        pid_ack,
   output logic        pid_err,
   input  logic        wdog_en,
   output logic        wr_en,
   output logic [9:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        estop_active
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ES0  = 3'd1;
   localparam logic [2:0] S_ES1  = 3'd2;
   localparam logic [2:0] S_ES2  = 3'd3;
   localparam logic [2:0] S_ES3  = 3'd4;
   localparam logic [2:0] S_ES4  = 3'd5;

   localparam logic PTR_HOST = 1'b0;
   localparam logic PTR_PID  = 1'b1;

   localparam logic [9:0]  A_HOST_LO = 10'd25;
   localparam logic [9:0]  A_HOST_HI = 10'd44;
   localparam logic [9:0]  A_PID_LO  = 10'd33;
   localparam logic [9:0]  A_PID_HI  = 10'd36;
   localparam logic [9:0]  A_ALLSTOP = 10'd40;
   localparam logic [9:0]  A_DUTY0   = 10'd33;
   localparam logic [9:0]  A_DUTY1   = 10'd34;
   localparam logic [9:0]  A_DUTY2   = 10'd35;
   localparam logic [9:0]  A_DUTY3   = 10'd36;
   localparam logic [15:0] D_ALLSTOP = 16'h001F;
   localparam logic [15:0] D_ZERO    = 16'h0000;

   logic [2:0]  state;
   logic        ptr;
   logic [23:0] wdog_cnt;

   logic host_ok;
   logic pid_ok;
   logic host_elig;
   logic pid_elig;
   logic in_idle;
   logic wdog_tc;
   logic grant_host;
   logic grant_pid;
   logic fire;

   always_comb begin
      host_ok   = (host_addr >= A_HOST_LO) && (host_addr <= A_HOST_HI);
      pid_ok    = (pid_addr >= A_PID_LO) && (pid_addr <= A_PID_HI) && !estop_active;
      // A requester whose ack is on the bus this cycle is still holding req
      // from the transfer just completed; it must not be granted again.
      host_elig = host_req && !host_ack;
      pid_elig  = pid_req && !pid_ack;
      in_idle   = (state == S_IDLE);
      wdog_tc   = wdog_en && !estop_active && (wdog_cnt == TIMEOUT_CYCLES - 24'd1);
      // Round-robin: on a tie the requester that was not granted last wins.
      grant_host = in_idle && host_elig && (!pid_elig || (ptr == PTR_PID));
      // A host grant on the terminal cycle resets the watchdog instead.
      fire       = in_idle && wdog_tc && !grant_host;
      grant_pid  = in_idle && pid_elig && !grant_host && !fire;
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         ptr          <= PTR_PID;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         host_ack     <= 1'b0;
         host_err     <= 1'b0;
         pid_ack      <= 1'b0;
         pid_err      <= 1'b0;
         estop_active <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         host_ack <= 1'b0;
         host_err <= 1'b0;
         pid_ack  <= 1'b0;
         pid_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fire) begin
                  state        <= S_ES0;
                  wr_en        <= 1'b1;
                  wr_addr      <= A_ALLSTOP;
                  wr_data      <= D_ALLSTOP;
                  estop_active <= 1'b1;
               end else if (grant_host) begin
                  ptr      <= PTR_HOST;
                  host_ack <= 1'b1;
                  host_err <= !host_ok;
                  if (host_ok) begin
                     wr_en   <= 1'b1;
                     wr_addr <= host_addr;
                     wr_data <= host_data;
                     if (host_addr == A_ALLSTOP) begin
                        estop_active <= 1'b0;
                     end
                  end
               end else if (grant_pid) begin
                  ptr     <= PTR_PID;
                  pid_ack <= 1'b1;
                  pid_err <= !pid_ok;
                  if (pid_ok) begin
                     wr_en   <= 1'b1;
                     wr_addr <= pid_addr;
                     wr_data <= pid_data;
                  end
               end
            end
            // Each ES state shows its own write; the register updated here
            // is the write belonging to the following state.
            S_ES0: begin
               state   <= S_ES1;
               wr_en   <= 1'b1;
               wr_addr <= A_DUTY0;
               wr_data <= D_ZERO;
            end
            S_ES1: begin
               state   <= S_ES2;
               wr_en   <= 1'b1;
               wr_addr <= A_DUTY1;
               wr_data <= D_ZERO;
            end
            S_ES2: begin
               state   <= S_ES3;
               wr_en   <= 1'b1;
               wr_addr <= A_DUTY2;
               wr_data <= D_ZERO;
            end
            S_ES3: begin
               state   <= S_ES4;
               wr_en   <= 1'b1;
               wr_addr <= A_DUTY3;
               wr_data <= D_ZERO;
            end
            S_ES4: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         wdog_cnt <= '0;
      end else if (!wdog_en || estop_active || host_ack || grant_host || fire) begin
         wdog_cnt <= '0;
      end else begin
         wdog_cnt <= wdog_cnt + 24'd1;
      end
   end

endmodule

// File: tb/tb_cmd_reg_arbiter.sv
module tb_cmd_reg_arbiter;

   logic        SYS_CLK;
   logic        RST;
   logic        host_req;
   logic [9:0]  host_addr;
   logic [15:0] host_data;
   logic        host_ack;
   logic        host_err;
   logic        pid_req;
   logic [9:0]  pid_addr;
   logic [15:0] pid_data;
   logic        pid_ack;
   logic        pid_err;
   logic        wdog_en;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic        estop_active;

   cmd_reg_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
      .SYS_CLK      (SYS_CLK),
      .RST          (RST),
      .host_req     (host_req),
      .host_addr    (host_addr),
      .host_data    (host_data),
      .host_ack     (host_ack),
      .host_err     (host_err),
      .pid_req      (pid_req),
      .pid_addr     (pid_addr),
      .pid_data     (pid_data),
      .pid_ack      (pid_ack),
      .pid_err      (pid_err),
      .wdog_en      (wdog_en),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .estop_active (estop_active)
   );

   typedef struct packed {
      logic        we;
      logic [9:0]  addr;
      logic [15:0] data;
      logic        hack;
      logic        herr;
      logic        pack;
      logic        perr;
   } obs_t;

   obs_t  exp_q[$];
   int    cyc_q[$];
   string name_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial begin
      SYS_CLK = 1'b0;
      forever #5 SYS_CLK = ~SYS_CLK;
   end

   always @(posedge SYS_CLK) cyc <= cyc + 1;

   // Monitor: every cycle with bus or ack activity is popped against the queue.
   always @(negedge SYS_CLK) begin : monitor
      obs_t  o;
      obs_t  e;
      int    ec;
      string en;
      if (wr_en || host_ack || pid_ack) begin
         o.we   = wr_en;
         o.addr = wr_en ? wr_addr : 10'd0;
         o.data = wr_en ? wr_data : 16'd0;
         o.hack = host_ack;
         o.herr = host_err;
         o.pack = pid_ack;
         o.perr = pid_err;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output cyc=%0d got=%h required=nothing", cyc, o);
         end else begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            en = name_q.pop_front();
            if (o !== e || cyc != ec) begin
               bad++;
               $display("FAIL %s got=%h at cyc %0d required=%h at cyc %0d", en, o, cyc, e, ec);
            end
         end
      end
   end

   task automatic push(input string n, input int c, input logic we, input logic [9:0] a,
                       input logic [15:0] d, input logic ha, input logic he,
                       input logic pa, input logic pe);
      obs_t e;
      e.we = we; e.addr = a; e.data = d;
      e.hack = ha; e.herr = he; e.pack = pa; e.perr = pe;
      exp_q.push_back(e);
      cyc_q.push_back(c);
      name_q.push_back(n);
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", n, act, req);
      end
   endtask

   task automatic do_reset(input logic wd, output int r);
      @(negedge SYS_CLK);
      RST = 1'b1; host_req = 1'b0; pid_req = 1'b0; wdog_en = wd;
      repeat (2) @(negedge SYS_CLK);
      chk("reset_outputs", {wr_en, wr_addr, wr_data, host_ack, host_err, pid_ack, pid_err,
                            estop_active}, 32'd0);
      RST = 1'b0;
      r = cyc;
   endtask

   task automatic issue(input logic h, input logic p, input logic [9:0] ha, input logic [15:0] hd,
                        input logic [9:0] pa, input logic [15:0] pd, output int c);
      @(negedge SYS_CLK);
      if (h) begin host_addr = ha; host_data = hd; host_req = 1'b1; end
      if (p) begin pid_addr = pa; pid_data = pd; pid_req = 1'b1; end
      c = cyc;
   endtask

   // Holds each request until its ack is seen; returns on that negedge.
   task automatic run_until_done();
      int n;
      n = 0;
      while ((host_req || pid_req) && n < 20) begin
         @(negedge SYS_CLK);
         n++;
         if (host_ack) host_req = 1'b0;
         if (pid_ack)  pid_req  = 1'b0;
      end
      total++;
      if (host_req || pid_req) begin
         bad++;
         $display("FAIL ack_timeout got=req_still_pending required=ack_within_20");
         host_req = 1'b0;
         pid_req  = 1'b0;
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge SYS_CLK);
   endtask

   logic        rj_pid  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [9:0]  rj_addr [6] = '{10'd25, 10'd10, 10'd24, 10'd45, 10'd32, 10'd37};

   initial begin : main
      int r;
      int c;
      RST = 1'b1; host_req = 1'b0; pid_req = 1'b0; wdog_en = 1'b0;
      host_addr = '0; host_data = '0; pid_addr = '0; pid_data = '0;

      // Single host write right after reset
      do_reset(1'b0, r);
      issue(1'b1, 1'b0, 10'd25, 16'h0123, 10'd0, 16'd0, c);
      push("host_w25", c + 1, 1'b1, 10'd25, 16'h0123, 1'b1, 1'b0, 1'b0, 1'b0);
      run_until_done();

      // Tie from reset: host first, PID next cycle
      do_reset(1'b0, r);
      issue(1'b1, 1'b1, 10'd29, 16'hA5A5, 10'd33, 16'h1234, c);
      push("tie_host", c + 1, 1'b1, 10'd29, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
      push("tie_pid",  c + 2, 1'b1, 10'd33, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
      run_until_done();

      // Host alone (top of range), then tie goes to PID
      issue(1'b1, 1'b0, 10'd44, 16'hBEEF, 10'd0, 16'd0, c);
      push("host_w44", c + 1, 1'b1, 10'd44, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      run_until_done();
      issue(1'b1, 1'b1, 10'd25, 16'h5555, 10'd36, 16'h6666, c);
      push("rr_pid",  c + 1, 1'b1, 10'd36, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0);
      push("rr_host", c + 2, 1'b1, 10'd25, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
      run_until_done();

      // Out-of-range rejections
      for (int i = 0; i < 6; i++) begin
         if (rj_pid[i]) begin
            issue(1'b0, 1'b1, 10'd0, 16'd0, rj_addr[i], 16'hFFFF, c);
            push("pid_reject", c + 1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
         end else begin
            issue(1'b1, 1'b0, rj_addr[i], 16'hFFFF, 10'd0, 16'd0, c);
            push("host_reject", c + 1, 1'b0, 10'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
         end
         run_until_done();
      end

      // Watchdog fire with no host traffic
      do_reset(1'b1, r);
      push("es0", r + 16, 1'b1, 10'd40, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es1", r + 17, 1'b1, 10'd33, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es2", r + 18, 1'b1, 10'd34, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es3", r + 19, 1'b1, 10'd35, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es4", r + 20, 1'b1, 10'd36, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(r + 15);
      chk("estop_before_fire", {31'd0, estop_active}, 32'd0);
      wait_cyc(r + 16);
      chk("estop_in_es0", {31'd0, estop_active}, 32'd1);
      wait_cyc(r + 21);
      issue(1'b0, 1'b1, 10'd0, 16'd0, 10'd34, 16'h4444, c);
      push("pid_reject_estop", c + 1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      run_until_done();
      chk("estop_held", {31'd0, estop_active}, 32'd1);
      issue(1'b1, 1'b0, 10'd40, 16'h0000, 10'd0, 16'd0, c);
      push("host_clear_estop", c + 1, 1'b1, 10'd40, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      run_until_done();
      chk("estop_cleared", {31'd0, estop_active}, 32'd0);
      wdog_en = 1'b0;
      issue(1'b0, 1'b1, 10'd0, 16'd0, 10'd34, 16'h4444, c);
      push("pid_w34_after_clear", c + 1, 1'b1, 10'd34, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b0);
      run_until_done();

      // PID request on the terminal-count cycle waits out the sequence
      do_reset(1'b1, r);
      push("es0_b", r + 16, 1'b1, 10'd40, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es1_b", r + 17, 1'b1, 10'd33, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es2_b", r + 18, 1'b1, 10'd34, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es3_b", r + 19, 1'b1, 10'd35, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es4_b", r + 20, 1'b1, 10'd36, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("pid_after_es4", r + 22, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_cyc(r + 15);
      pid_addr = 10'd35; pid_data = 16'h7777; pid_req = 1'b1;
      run_until_done();

      // Reset during ES2 aborts the sequence
      do_reset(1'b1, r);
      push("es0_c", r + 16, 1'b1, 10'd40, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es1_c", r + 17, 1'b1, 10'd33, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      push("es2_c", r + 18, 1'b1, 10'd34, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_cyc(r + 18);
      RST = 1'b1;
      @(negedge SYS_CLK);
      chk("abort_outputs", {30'd0, wr_en, estop_active}, 32'd0);
      wdog_en = 1'b0;
      RST = 1'b0;
      repeat (25) @(negedge SYS_CLK);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
